// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit_pkg : shared size codes, LSU state encoding, helpers |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package load_store_unit_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam int   BITS32 = 32;
  localparam int   BITS2  = 2;

  localparam logic [BITS2-1:0] SZ_BYTE = 2'b00;
  localparam logic [BITS2-1:0] SZ_HALF = 2'b01;
  localparam logic [BITS2-1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } lsu_state_t;

  // Size code 11 is treated as a fault alongside true misalignment.
  function automatic logic is_misaligned(input logic [BITS2-1:0] size,
                                         input logic [BITS2-1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = FALSE;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'b00);
      default: is_misaligned = TRUE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_lane : sub-word load extraction/extension and store lane merge   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lsu_lane
  import load_store_unit_pkg::*;
(
  input  logic [BITS32-1:0] i_word,
  input  logic [BITS2-1:0]  i_offset,
  input  logic [BITS2-1:0]  i_size,
  input  logic              i_unsigned,
  input  logic [15:0]       i_store_data,
  output logic [BITS32-1:0] o_load_value,
  output logic [BITS32-1:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  always_comb begin
    w_byte       = i_word[8*i_offset +: 8];
    w_half       = i_offset[1] ? i_word[31:16] : i_word[15:0];
    w_sign       = FALSE;
    o_load_value = i_word;
    o_store_word = i_word;
    case (i_size)
      SZ_BYTE: begin
        w_sign       = w_byte[7] & ~i_unsigned;
        o_load_value = {{24{w_sign}}, w_byte};
        o_store_word[8*i_offset +: 8] = i_store_data[7:0];
      end
      SZ_HALF: begin
        w_sign       = w_half[15] & ~i_unsigned;
        o_load_value = {{16{w_sign}}, w_half};
        if (i_offset[1]) o_store_word[31:16] = i_store_data;
        else             o_store_word[15:0]  = i_store_data;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit : single-op data-memory initiator with RMW sub-words |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              misaligned,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t  r_state, w_next;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_we;
  logic        r_unsigned;
  logic [15:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_accept;
  logic        w_fault;
  logic [31:0] w_load_value;
  logic [31:0] w_store_word;

  assign req_ready  = (r_state == ST_IDLE);
  assign stall      = req_valid && !req_ready;
  assign w_accept   = req_valid && req_ready;
  assign w_fault    = is_misaligned(req_size, req_addr[1:0]);
  assign resp_valid = (r_state == ST_DONE) || (r_state == ST_ERR);
  assign misaligned = (r_state == ST_ERR);
  assign resp_rdata = ((r_state == ST_DONE) && !r_we) ? r_rdata : 32'd0;

  // Lane logic works on the live read word so READ can capture or merge in one cycle.
  lsu_lane u_lane (
    .i_word       (mem_rdata),
    .i_offset     (r_off),
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_store_data (r_wdata),
    .o_load_value (w_load_value),
    .o_store_word (w_store_word)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_fault)                     w_next = ST_ERR;
          else if (!req_we)                w_next = ST_READ;
          else if (req_size == SZ_WORD)    w_next = ST_WRITE;
          else                             w_next = ST_READ;
        end
      end
      ST_READ:  w_next = r_we ? ST_WRITE : ST_DONE;
      ST_WRITE: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      ST_ERR:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_off      <= 2'b00;
      r_size     <= SZ_BYTE;
      r_we       <= FALSE;
      r_unsigned <= FALSE;
      r_wdata    <= 16'd0;
      r_rdata    <= 32'd0;
      mem_addr   <= '0;
      mem_rw     <= FALSE;
      mem_wdata  <= 32'd0;
    end else begin
      r_state <= w_next;
      mem_rw  <= (w_next == ST_WRITE);
      if (w_accept) begin
        r_off      <= req_addr[1:0];
        r_size     <= req_size;
        r_we       <= req_we;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata[15:0];
        if (!w_fault) begin
          mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
          if (req_we && (req_size == SZ_WORD)) mem_wdata <= req_wdata;
        end
      end
      if (r_state == ST_READ) begin
        if (r_we) mem_wdata <= w_store_word;
        else      r_rdata   <= w_load_value;
      end
    end
  end

endmodule
`default_nettype wire
